design_delay_line: RTL and testbench

- Parameterised synchronous delay line: presents `SIG_IN` on `Delay_sig_out` exactly `Nbits` clock cycles later.
- Used to re-align a multi-bit control/data signal with a pipelined datapath.
- Has a stall input and an output-valid flag, so downstream logic can tell when the pipe holds real post-reset data.

---
 rtl/delay_pkg.sv | 25 ++
 rtl/delay_stage.sv | 41 ++++
 rtl/design_delay_line.sv | 94 +++++++++
 tb/tb_design_delay_line.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared constants and helpers for the delay line block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DELAY_MAX_DEPTH : deepest legal delay line.
//   clog2_depth()   : bit width needed to count 0..depth inclusive.
package delay_pkg;

  localparam int DELAY_MAX_DEPTH = 64;

  // Width of a counter that must hold every value from 0 up to and including
  // depth. Always at least 1 bit.
  function automatic int clog2_depth(input int depth);
    int w;
    w = 1;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < (depth + 1)) begin
        w = w + 1;
      end
    end
    return w;
  endfunction

endpackage : delay_pkg

// File: rtl/delay_stage.sv
// One WIDTH-bit register stage of the delay line, with clear and enable.
// Latency: 1 enabled clock from d_i to q_o.
// Backpressure: en_i=0 holds the stored value; clear (rst_n=0) wins over en_i.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low clear
//   en_i   : load enable
//   d_i    : data to capture
//   q_o    : registered data
module delay_stage #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule : delay_stage

// File: rtl/design_delay_line.sv
// Parameterised synchronous delay line with stall and fill-valid flag.
// Latency: Nbits enabled clocks from SIG_IN to Delay_sig_out.
// Backpressure: en=0 freezes every stage, the fill counter and out_valid.
//
// Ports:
//   clk           : rising-edge clock (single domain)
//   rst_n         : synchronous active-low reset, overrides en
//   en            : shift enable
//   SIG_IN        : WIDTH-bit input to be delayed
//   Delay_sig_out : SIG_IN delayed by Nbits enabled cycles, straight from a register
//   out_valid     : high once Nbits enabled shifts have happened since reset
module design_delay_line
  import delay_pkg::*;
#(
  parameter int Nbits = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] SIG_IN,
  output logic [WIDTH-1:0] Delay_sig_out,
  output logic             out_valid
);

  // Reject illegal depths/widths at elaboration time.
  if ((Nbits < 1) || (Nbits > DELAY_MAX_DEPTH)) begin : g_bad_depth
    $error("design_delay_line: Nbits out of range 1..DELAY_MAX_DEPTH");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("design_delay_line: WIDTH must be at least 1");
  end

  localparam int CNT_W = clog2_depth(Nbits);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(Nbits);

  // ---------------------------------------------------------------------------
  // Register chain: stage 0 takes SIG_IN, stage i takes stage i-1.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] stage_q [Nbits];

  for (genvar i = 0; i < Nbits; i++) begin : g_stage
    logic [WIDTH-1:0] stage_in;

    if (i == 0) begin : g_head
      assign stage_in = SIG_IN;
    end else begin : g_body
      assign stage_in = stage_q[i-1];
    end

    delay_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (en),
      .d_i   (stage_in),
      .q_o   (stage_q[i])
    );
  end

  assign Delay_sig_out = stage_q[Nbits-1];

  // ---------------------------------------------------------------------------
  // Fill counter: counts enabled shifts since reset and saturates at Nbits.
  // out_valid is registered from the next-state count, so it rises on the
  // same edge that moves the first post-reset sample into the last stage.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             valid_q;
  logic             valid_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != CNT_FULL)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    valid_d = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;

endmodule : design_delay_line

// File: tb/tb_design_delay_line.sv
// Directed self-checking bench for design_delay_line.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_design_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Main instance: Nbits=2, WIDTH=3.
  logic       rst_n;
  logic       en;
  logic [2:0] sig_in;
  logic [2:0] dout;
  logic       dvalid;

  design_delay_line #(.Nbits(2), .WIDTH(3)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .SIG_IN        (sig_in),
    .Delay_sig_out (dout),
    .out_valid     (dvalid)
  );

  // Sweep instances: Nbits=1 and Nbits=4, WIDTH=8, shared stimulus.
  logic       rst_n_s;
  logic       en_s;
  logic [7:0] sig_s;
  logic [7:0] dout1;
  logic       dvalid1;
  logic [7:0] dout4;
  logic       dvalid4;

  design_delay_line #(.Nbits(1), .WIDTH(8)) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n_s),
    .en            (en_s),
    .SIG_IN        (sig_s),
    .Delay_sig_out (dout1),
    .out_valid     (dvalid1)
  );

  design_delay_line #(.Nbits(4), .WIDTH(8)) u_dut4 (
    .clk           (clk),
    .rst_n         (rst_n_s),
    .en            (en_s),
    .SIG_IN        (sig_s),
    .Delay_sig_out (dout4),
    .out_valid     (dvalid4)
  );

  // Advance one rising edge, then settle away from the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Main-DUT step: drive inputs, clock once, compare data and valid.
  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] s,
                      input logic [2:0] exp_out, input logic exp_vld);
    rst_n  = r;
    en     = e;
    sig_in = s;
    tick();
    check({tag, "_out"}, {5'd0, dout}, {5'd0, exp_out});
    check({tag, "_vld"}, {7'd0, dvalid}, {7'd0, exp_vld});
  endtask

  logic [7:0] m4 [4];
  logic [7:0] val;
  int         n4;

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    sig_in  = 3'b111;
    rst_n_s = 1'b0;
    en_s    = 1'b1;
    sig_s   = 8'h00;
    #2;

    // 1. Reset held 2 cycles with SIG_IN all ones.
    step("rst1", 1'b0, 1'b1, 3'b111, 3'd0, 1'b0);
    step("rst2", 1'b0, 1'b1, 3'b111, 3'd0, 1'b0);

    // 2. Basic latency: 0, then 2 for three cycles, then 3.
    step("lat_a", 1'b1, 1'b1, 3'd0, 3'd0, 1'b0);
    step("lat_b", 1'b1, 1'b1, 3'd2, 3'd0, 1'b1);
    step("lat_c", 1'b1, 1'b1, 3'd2, 3'd2, 1'b1);
    step("lat_d", 1'b1, 1'b1, 3'd2, 3'd2, 1'b1);
    step("lat_e", 1'b1, 1'b1, 3'd3, 3'd2, 1'b1);
    step("lat_f", 1'b1, 1'b1, 3'd3, 3'd3, 1'b1);

    // 3. Stall: stream 1,2,<stall x3>,3,4 then flush.
    step("stl_1", 1'b1, 1'b1, 3'd1, 3'd3, 1'b1);
    step("stl_2", 1'b1, 1'b1, 3'd2, 3'd1, 1'b1);
    step("stl_h0", 1'b1, 1'b0, 3'd7, 3'd1, 1'b1);
    step("stl_h1", 1'b1, 1'b0, 3'd6, 3'd1, 1'b1);
    step("stl_h2", 1'b1, 1'b0, 3'd5, 3'd1, 1'b1);
    step("stl_3", 1'b1, 1'b1, 3'd3, 3'd2, 1'b1);
    step("stl_4", 1'b1, 1'b1, 3'd4, 3'd3, 1'b1);
    step("stl_f", 1'b1, 1'b1, 3'd0, 3'd4, 1'b1);

    // 4. Mid-stream reset after 5,6,7, then refill.
    step("mid_5", 1'b1, 1'b1, 3'd5, 3'd0, 1'b1);
    step("mid_6", 1'b1, 1'b1, 3'd6, 3'd5, 1'b1);
    step("mid_7", 1'b1, 1'b1, 3'd7, 3'd6, 1'b1);
    step("mid_rst", 1'b0, 1'b1, 3'd1, 3'd0, 1'b0);
    step("mid_r1", 1'b1, 1'b1, 3'd1, 3'd0, 1'b0);
    step("mid_r2", 1'b1, 1'b1, 3'd2, 3'd1, 1'b1);
    step("mid_r3", 1'b1, 1'b1, 3'd3, 3'd2, 1'b1);

    // 6. Reset beats enable: 5 must not enter the line.
    step("pri_rst", 1'b0, 1'b1, 3'b101, 3'd0, 1'b0);
    step("pri_hold", 1'b1, 1'b0, 3'b110, 3'd0, 1'b0);
    step("pri_s0", 1'b1, 1'b1, 3'd0, 3'd0, 1'b0);
    step("pri_s1", 1'b1, 1'b1, 3'd0, 3'd0, 1'b1);

    // 5. Parameter sweep with a random stream against a bench shift model.
    rst_n_s = 1'b0;
    tick();
    check("swp_rst_out1", dout1, 8'h00);
    check("swp_rst_out4", dout4, 8'h00);
    check("swp_rst_vld4", {7'd0, dvalid4}, 8'h00);
    for (int k = 0; k < 4; k++) m4[k] = 8'h00;
    n4 = 0;
    rst_n_s = 1'b1;
    for (int k = 0; k < 50; k++) begin
      val   = 8'($urandom_range(0, 255));
      sig_s = val;
      tick();
      m4[3] = m4[2];
      m4[2] = m4[1];
      m4[1] = m4[0];
      m4[0] = val;
      if (n4 < 4) n4++;
      check("swp_out1", dout1, val);
      check("swp_vld1", {7'd0, dvalid1}, 8'h01);
      check("swp_out4", dout4, m4[3]);
      check("swp_vld4", {7'd0, dvalid4}, (n4 == 4) ? 8'h01 : 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_design_delay_line
